seq_step_counter: RTL and testbench

Parametrised successor to the single-digit even-number stepper: a multi-digit, debounced, bidirectional arithmetic-sequence counter driving active-low seven-segment displays. Each press of KEY[0] advances the value by STEP from INIT. KEY[1] toggles count direction. The value wraps at both ends of the sequence. The block sits at board top level between the push-buttons and the HEX outputs, and runs from the board clock rather than from a button edge.

---
 rtl/seq_step_pkg.sv | 59 +++++
 rtl/key_debounce.sv | 54 +++++
 rtl/seq_step_counter.sv | 119 +++++++++++
 tb/tb_seq_step_counter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_step_pkg.sv
// Shared display helpers for seq_step_counter: segment bit order, a
// hex-to-seven-segment encoder and a binary-to-BCD converter.
package seq_step_pkg;

    // Segment bit positions inside a 7-bit digit pattern
    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    // Converter is sized for the widest display (4 digits, 0..9999)
    localparam int unsigned BCD_IN_W  = 14;
    localparam int unsigned BCD_OUT_W = 16;

    // Active-high segment pattern for one hex digit
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        seg = '0;
        unique case (digit)
            4'h0: seg = 7'h3f;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5b;
            4'h3: seg = 7'h4f;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6d;
            4'h6: seg = 7'h7d;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7f;
            4'h9: seg = 7'h6f;
            4'ha: seg = 7'h77;
            4'hb: seg = 7'h7c;
            4'hc: seg = 7'h39;
            4'hd: seg = 7'h5e;
            4'he: seg = 7'h79;
            4'hf: seg = 7'h71;
            default: seg = '0;
        endcase
        return seg;
    endfunction

    // Combinational double-dabble: shift-and-add-3
    function automatic logic [BCD_OUT_W-1:0] bin_to_bcd(input logic [BCD_IN_W-1:0] bin);
        logic [BCD_OUT_W-1:0] bcd;
        bcd = '0;
        for (int i = BCD_IN_W - 1; i >= 0; i--) begin
            for (int d = 0; d < BCD_OUT_W / 4; d++) begin
                if (bcd[4*d +: 4] >= 4'd5) begin
                    bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
                end
            end
            bcd = {bcd[BCD_OUT_W-2:0], bin[i]};
        end
        return bcd;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchroniser followed by a counting
// debouncer. Emits a one-cycle press pulse on an accepted 1->0 level change.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic key,
    output logic press
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // Synchroniser and debouncer state; idle level is released (1)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= key;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    // Count consecutive disagreeing samples; any agreement clears the count
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                press_d  = stable_q & ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/seq_step_counter.sv
// Debounced bidirectional arithmetic-sequence counter with a multi-digit
// active-low seven-segment display. KEY[0] steps by STEP, KEY[1] flips the
// direction; the value wraps between INIT and TOP in both directions.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seq_step_counter
    import seq_step_pkg::*;
#(
    parameter int unsigned DIGITS          = 2,
    parameter int unsigned STEP            = 2,
    parameter int unsigned INIT            = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [1:0]                      KEY,
    output logic [7*DIGITS-1:0]             HEX,
    output logic [$clog2(10**DIGITS)-1:0]   value,
    output logic                            down,
    output logic                            wrap
);

    localparam int unsigned VW      = $clog2(10**DIGITS);
    localparam int unsigned BW      = 4 * DIGITS;
    localparam int unsigned MAX_VAL = 10**DIGITS - 1;
    localparam int unsigned TOP     = INIT + ((MAX_VAL - INIT) / STEP) * STEP;

    logic          step_ev, dir_ev;
    logic [VW-1:0] value_q, value_d;
    logic          down_q, down_d;
    logic          wrap_q, wrap_d;
    logic [BW-1:0] bcd;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_step (
        .clock(clock),
        .reset(reset),
        .key  (KEY[0]),
        .press(step_ev)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_dir (
        .clock(clock),
        .reset(reset),
        .key  (KEY[1]),
        .press(dir_ev)
    );

    // Sequence value, direction and wrap pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value_q <= VW'(INIT);
            down_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            down_q  <= down_d;
            wrap_q  <= wrap_d;
        end
    end

    // Step uses the current direction; a same-cycle toggle applies afterwards
    always_comb begin
        int unsigned cur;
        cur     = 32'(value_q);
        value_d = value_q;
        down_d  = down_q ^ dir_ev;
        wrap_d  = 1'b0;
        if (step_ev) begin
            if (!down_q) begin
                if (cur + STEP > TOP) begin
                    value_d = VW'(INIT);
                    wrap_d  = 1'b1;
                end else begin
                    value_d = VW'(cur + STEP);
                end
            end else begin
                if (cur < INIT + STEP) begin
                    value_d = VW'(TOP);
                    wrap_d  = 1'b1;
                end else begin
                    value_d = VW'(cur - STEP);
                end
            end
        end
    end

    assign bcd = BW'(bin_to_bcd(BCD_IN_W'(value_q)));

    // Per-digit encode, scanning from the most significant digit down
    always_comb begin
        logic [3:0] digit;
        logic [6:0] seg;
`ifdef LEADING_ZERO_BLANK_EN
        logic       lead;
        lead = 1'b1;
`endif
        HEX = '1;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            digit = bcd[4*d +: 4];
            seg   = seg_encode(digit);
`ifdef LEADING_ZERO_BLANK_EN
            if (lead && digit == 4'd0 && d != 0) begin
                seg = '0;
            end else begin
                lead = 1'b0;
            end
`endif
            HEX[7*d +: 7] = ~seg;
        end
    end

    assign value = value_q;
    assign down  = down_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_seq_step_counter.sv
// Scoreboard bench for seq_step_counter: a 2-digit instance (STEP=2, INIT=2)
// and a 3-digit instance (STEP=5, INIT=0), both with a 4-cycle debounce.
module tb_seq_step_counter;

    localparam int unsigned TOP2 = 98;
    localparam int unsigned TOP3 = 995;
    localparam int LAT = 7;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  KEY, KEY3;
    logic [13:0] HEX;
    logic [6:0]  value;
    logic        down, wrap;
    logic [20:0] HEX3;
    logic [9:0]  value3;
    logic        down3, wrap3;

    typedef struct {
        int unsigned v;
        bit          d;
        bit          w;
    } exp_t;

    exp_t        sbq[$];
    int          vectors = 0;
    int          miscompares = 0;
    int unsigned m_val, m3_val;
    bit          m_down;

    seq_step_counter #(
        .DIGITS(2), .STEP(2), .INIT(2), .DEBOUNCE_CYCLES(4)
    ) u_dut (
        .clock(clock), .reset(reset), .KEY(KEY), .HEX(HEX),
        .value(value), .down(down), .wrap(wrap)
    );

    seq_step_counter #(
        .DIGITS(3), .STEP(5), .INIT(0), .DEBOUNCE_CYCLES(4)
    ) u_dut3 (
        .clock(clock), .reset(reset), .KEY(KEY3), .HEX(HEX3),
        .value(value3), .down(down3), .wrap(wrap3)
    );

    always #5 clock = ~clock;

    initial begin
        #3_000_000;
        $display("FAIL timeout: run did not finish, got %0d vectors, required completion",
                 vectors);
        $fatal(1);
    end

    function automatic logic [6:0] seg7(input int unsigned d);
        logic [6:0] tbl [10];
        tbl = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};
        return tbl[d];
    endfunction

    function automatic logic [13:0] hex2(input int unsigned v);
        logic [6:0] hi;
        hi = ~seg7(v / 10);
`ifdef LEADING_ZERO_BLANK_EN
        if (v / 10 == 0) hi = 7'h7f;
`endif
        return {hi, ~seg7(v % 10)};
    endfunction

    function automatic logic [20:0] hex3(input int unsigned v);
        logic [6:0] h, t;
        h = ~seg7(v / 100);
        t = ~seg7((v / 10) % 10);
`ifdef LEADING_ZERO_BLANK_EN
        if (v / 100 == 0) h = 7'h7f;
        if (v / 10 == 0) t = 7'h7f;
`endif
        return {h, t, ~seg7(v % 10)};
    endfunction

    task automatic apply_reset();
        KEY   = 2'b11;
        KEY3  = 2'b11;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset  = 1'b1;
        m_val  = 2;
        m_down = 1'b0;
        m3_val = 0;
        sbq.delete();
        @(negedge clock);
    endtask

    // Push model expectation, press keys for 8 cycles, then compare on change
    task automatic press(input bit on3, input bit s, input bit t);
        exp_t        e;
        int unsigned pv, cv;
        bit          pd, cd, cw, seen;
        int          lat;
        e.w = 1'b0;
        if (on3) begin
            if (m3_val + 5 > TOP3) begin
                m3_val = 0;
                e.w = 1'b1;
            end else begin
                m3_val = m3_val + 5;
            end
            e.v = m3_val;
            e.d = 1'b0;
        end else begin
            if (s) begin
                if (!m_down) begin
                    if (m_val + 2 > TOP2) begin m_val = 2; e.w = 1'b1; end
                    else m_val = m_val + 2;
                end else begin
                    if (m_val < 4) begin m_val = TOP2; e.w = 1'b1; end
                    else m_val = m_val - 2;
                end
            end
            if (t) m_down = ~m_down;
            e.v = m_val;
            e.d = m_down;
        end
        sbq.push_back(e);
        pv = on3 ? 32'(value3) : 32'(value);
        pd = on3 ? down3 : down;
        if (on3) KEY3 = {~t, ~s};
        else KEY = {~t, ~s};
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clock);
            if (c == 9) begin
                KEY  = 2'b11;
                KEY3 = 2'b11;
            end
            cv = on3 ? 32'(value3) : 32'(value);
            cd = on3 ? down3 : down;
            cw = on3 ? wrap3 : wrap;
            if (!seen && (cv != pv || cd != pd)) begin
                seen = 1'b1;
                lat  = c;
                e    = sbq.pop_front();
                vectors += 4;
                if (cv !== e.v) begin
                    miscompares++;
                    $display("FAIL step_value: got %0d, required %0d", cv, e.v);
                end
                if (cd !== e.d) begin
                    miscompares++;
                    $display("FAIL step_down: got %0d, required %0d", cd, e.d);
                end
                if (cw !== e.w) begin
                    miscompares++;
                    $display("FAIL step_wrap: got %0d, required %0d (value %0d)", cw, e.w, cv);
                end
                if (c != LAT) begin
                    miscompares++;
                    $display("FAIL step_latency: got %0d cycles, required %0d", c, LAT);
                end
            end else if (seen && c == lat + 1) begin
                vectors++;
                if (cw !== 1'b0) begin
                    miscompares++;
                    $display("FAIL wrap_width: wrap still %0d one cycle later, required 0", cw);
                end
            end else if (!seen && cw !== 1'b0) begin
                vectors++;
                miscompares++;
                $display("FAIL wrap_spurious: got %0d before event, required 0", cw);
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL no_event: value %0d unchanged, required %0d", pv, e.v);
            void'(sbq.pop_front());
        end
    endtask

    task automatic test_reset();
        apply_reset();
        vectors += 5;
        if (value !== 7'd2) begin
            miscompares++; $display("FAIL reset_value: got %0d, required 2", value);
        end
        if (down !== 1'b0 || wrap !== 1'b0) begin
            miscompares++; $display("FAIL reset_flags: got down %0d wrap %0d, required 0 0", down, wrap);
        end
        if (HEX !== hex2(2)) begin
            miscompares++; $display("FAIL reset_hex: got %h, required %h", HEX, hex2(2));
        end
        if (value3 !== 10'd0) begin
            miscompares++; $display("FAIL reset_value3: got %0d, required 0", value3);
        end
        if (HEX3 !== hex3(0)) begin
            miscompares++; $display("FAIL reset_hex3: got %h, required %h", HEX3, hex3(0));
        end
    endtask

    task automatic test_count_up();
        for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 1'b0);
        vectors++;
        if (HEX !== hex2(8)) begin
            miscompares++; $display("FAIL hex_08: got %h, required %h", HEX, hex2(8));
        end
    endtask

    task automatic test_wrap_up();
        while (m_val < TOP2) press(1'b0, 1'b1, 1'b0);
        vectors++;
        if (HEX !== hex2(98)) begin
            miscompares++; $display("FAIL hex_98: got %h, required %h", HEX, hex2(98));
        end
        press(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_toggle();
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_bounce();
        int lat;
        apply_reset();
        for (int b = 0; b < 3; b++) begin
            KEY[0] = 1'b0;
            repeat (3) @(negedge clock);
            KEY[0] = 1'b1;
            repeat (2) @(negedge clock);
        end
        repeat (6) @(negedge clock);
        vectors++;
        if (value !== 7'd2) begin
            miscompares++; $display("FAIL bounce_ignored: got %0d, required 2", value);
        end
        sbq.push_back('{v: 4, d: 1'b0, w: 1'b0});
        KEY[0] = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (lat == 0 && value != 7'd2) lat = c;
        end
        KEY[0] = 1'b1;
        repeat (10) @(negedge clock);
        vectors += 2;
        if (lat != LAT) begin
            miscompares++; $display("FAIL bounce_latency: got %0d cycles, required %0d", lat, LAT);
        end
        m_val = 4;
        if (value !== 7'(sbq[0].v)) begin
            miscompares++; $display("FAIL bounce_single: got %0d, required %0d", value, sbq[0].v);
        end
        void'(sbq.pop_front());
    endtask

    task automatic test_simultaneous();
        apply_reset();
        for (int i = 0; i < 4; i++) press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b1);
        press(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 24; i++) press(1'b0, 1'b1, 1'b0);
        KEY[0] = 1'b0;
        repeat (4) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        vectors += 2;
        if (value !== 7'd2) begin
            miscompares++; $display("FAIL async_reset_value: got %0d, required 2", value);
        end
        if (wrap !== 1'b0 || down !== 1'b0) begin
            miscompares++; $display("FAIL async_reset_flags: got down %0d wrap %0d, required 0 0", down, wrap);
        end
        KEY = 2'b11;
        @(negedge clock);
        reset  = 1'b1;
        m_val  = 2;
        m_down = 1'b0;
        repeat (12) @(negedge clock);
        vectors++;
        if (value !== 7'd2) begin
            miscompares++; $display("FAIL reset_discard: got %0d, required 2", value);
        end
    endtask

    task automatic test_digits3();
        while (m3_val < TOP3) press(1'b1, 1'b1, 1'b0);
        vectors++;
        if (HEX3 !== hex3(995)) begin
            miscompares++; $display("FAIL hex3_995: got %h, required %h", HEX3, hex3(995));
        end
        press(1'b1, 1'b1, 1'b0);
        vectors++;
        if (HEX3 !== hex3(0)) begin
            miscompares++; $display("FAIL hex3_0: got %h, required %h", HEX3, hex3(0));
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap_up();
        test_toggle();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_digits3();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
